sprite_rom_server: RTL and testbench

- Responder end of the sprite ROM read interface: time-multiplexes one synchronous sprite ROM among N sprite requesters.
- Replaces OR-ing sprite addresses onto a shared ROM address bus.
- Per-client request/grant handshake, round-robin arbitration, fixed-latency pipelined read return routed to the requesting client's data register.
- Sits between sprite engines and the `rom` instance in the top level, on board_clk.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_rom_server_if.sv | 20 ++
 rtl/sprite_rom_server_rr_arbiter.sv | 50 +++++
 rtl/sprite_rom_server.sv | 102 ++++++++++
 tb/tb_sprite_rom_server.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite constants and types.
// The ROM geometry lives here, together with the return-pipeline entry type
// used by sprite_rom_server.
package sprite_pkg;

    localparam int CIDXW       = 3;                     // colour index width
    localparam int CAT_WIDTH   = 30;
    localparam int CAT_HEIGHT  = 32;
    localparam int CATROMDEPTH = CAT_WIDTH * CAT_HEIGHT; // 960 words
    localparam int AW          = $clog2(CATROMDEPTH);    // 10 address bits

    // Up to eight requesters share one ROM, so a client id fits in 3 bits.
    localparam int MAX_CLIENTS = 8;
    typedef logic [$clog2(MAX_CLIENTS)-1:0] client_id_t;

    // One slot of the return pipeline. It tracks a read from issue until its
    // data comes back from the ROM.
    typedef struct packed {
        logic       valid;
        client_id_t id;
    } ret_entry_t;

endpackage

// File: rtl/sprite_rom_server_if.sv
// Client-side bundle of the sprite ROM read interface.
// The master side belongs to the sprite engines and the slave side to
// sprite_rom_server. Client i uses bits [i*AW +: AW] of addr and bits
// [i*DW +: DW] of rd_data.
interface sprite_rom_server_if
    import sprite_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int AW        = sprite_pkg::AW,
    parameter int DW        = sprite_pkg::CIDXW
);
    logic [N_CLIENTS-1:0]    req;
    logic [N_CLIENTS*AW-1:0] addr;
    logic [N_CLIENTS-1:0]    gnt;
    logic [N_CLIENTS-1:0]    rd_valid;
    logic [N_CLIENTS*DW-1:0] rd_data;

    modport master (output req, addr, input gnt, rd_valid, rd_data);
    modport slave  (input req, addr, output gnt, rd_valid, rd_data);
endinterface

// File: rtl/sprite_rom_server_rr_arbiter.sv
// Round-robin arbiter, N requesters.
// The search starts one past the most recent winner, so a client that was
// just served drops to the lowest priority. After reset client 0 wins first.
// The grant is combinational and is forced to zero while Reset is high.
module rr_arbiter
    import sprite_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          board_clk,
    input  logic          Reset,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [IW-1:0] last;
    logic [IW-1:0] cand;

    // Pick the first active request after last, wrapping modulo N.
    always_comb begin
        // NOTE: every output of this block gets a default first; otherwise a
        // path that skips an assignment would infer a latch.
        gnt    = '0;
        winner = last;
        valid  = 1'b0;
        cand   = '0;
        if (!Reset) begin
            for (int k = 1; k <= N; k++) begin
                cand = IW'((int'(last) + k) % N);
                if (!valid && req[cand]) begin
                    valid  = 1'b1;
                    winner = cand;
                end
            end
        end
        if (valid) gnt[winner] = 1'b1;
    end

    // Move the priority pointer to the winner. Hold it when no client requests.
    always_ff @(posedge board_clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples values from before the clock edge.
        if (Reset)      last <= IW'(N - 1);
        else if (valid) last <= winner;
    end

endmodule

// File: rtl/sprite_rom_server.sv
// sprite_rom_server: shares one synchronous sprite ROM among N_CLIENTS sprite
// engines.
// Each cycle a round-robin arbiter picks one requester and registers its
// address onto rom_addr. A {valid, id} shift register of depth ROM_LAT+1
// tracks each read until rom_data is valid. The returned data then goes into
// the requesting client's rd_data slice, and that client's rd_valid pulses for
// one cycle. The result appears ROM_LAT+2 cycles after the grant.
// Optional build macro SPRITE_ROM_STATS_EN adds a saturating counter on
// stall_cnt: it counts cycles in which a client lost arbitration. Without the
// macro, stall_cnt is tied to zero.
module sprite_rom_server
    import sprite_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int AW        = sprite_pkg::AW,
    parameter int DW        = sprite_pkg::CIDXW,
    parameter int ROM_LAT   = 1
) (
    input  logic                board_clk,
    input  logic                Reset,
    sprite_rom_server_if.slave  cl,
    output logic [AW-1:0]       rom_addr,
    input  logic [DW-1:0]       rom_data,
    output logic [15:0]         stall_cnt
);

    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    logic [IW-1:0] winner;
    logic          granted;
    logic [AW-1:0] win_addr;
    ret_entry_t    pipe [ROM_LAT+1];
    ret_entry_t    tail;

    rr_arbiter #(.N(N_CLIENTS), .IW(IW)) u_arb (
        .board_clk (board_clk),
        .Reset     (Reset),
        .req       (cl.req),
        .gnt       (cl.gnt),
        .winner    (winner),
        .valid     (granted)
    );

    // Select the address of the granted client. The grant is one-hot.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (cl.gnt[i]) win_addr = cl.addr[i*AW +: AW];
        end
    end

    // Register the winning address. Hold it when there is no grant.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)        rom_addr <= '0;
        else if (granted) rom_addr <= win_addr;
    end

    // Shift {valid, id} along with the ROM read. A cycle with no grant pushes
    // a bubble.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i <= ROM_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: granted, id: client_id_t'(winner)};
            for (int i = 1; i <= ROM_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail = pipe[ROM_LAT];

    // Deliver the returning word to its client. Other clients' slices hold.
    always_ff @(posedge board_clk or posedge Reset) begin
        // NOTE: the per-client data registers are reset as well. Clients must
        // see all-zero rd_data after reset, not leftover ROM words.
        if (Reset) begin
            cl.rd_valid <= '0;
            cl.rd_data  <= '0;
        end else begin
            cl.rd_valid <= '0;
            for (int i = 0; i < N_CLIENTS; i++) begin
                if (tail.valid && tail.id == client_id_t'(i)) begin
                    cl.rd_valid[i]         <= 1'b1;
                    cl.rd_data[i*DW +: DW] <= rom_data;
                end
            end
        end
    end

`ifdef SPRITE_ROM_STATS_EN
    // Count cycles where some requester was left waiting. Saturates at all-ones.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (|(cl.req & ~cl.gnt) && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sprite_rom_server.sv
// Self-checking bench for sprite_rom_server (N_CLIENTS=4, ROM_LAT=1).
// The reference model works at transaction level. It picks the round-robin
// winner from a pointer, tracks the expected rom_addr and the stall count,
// and keeps a queue of expected returns, each due ROM_LAT+2 cycles after its
// grant. Set SPRITE_ROM_STATS_EN for both the DUT and the bench.
module tb_sprite_rom_server;
    import sprite_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 1;

    typedef struct {
        int              due;
        int              id;
        logic [CIDXW-1:0] data;
    } ret_t;

    logic              board_clk = 1'b0;
    logic              Reset     = 1'b1;
    logic [AW-1:0]     rom_addr;
    logic [CIDXW-1:0]  rom_data  = '0;
    logic [15:0]       stall_cnt;
    logic [CIDXW-1:0]  rom_mem [1024];

    sprite_rom_server_if #(.N_CLIENTS(N), .AW(AW), .DW(CIDXW)) bus ();

    sprite_rom_server #(.N_CLIENTS(N), .AW(AW), .DW(CIDXW), .ROM_LAT(LAT)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .cl        (bus),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .stall_cnt (stall_cnt)
    );

    always #5 board_clk = ~board_clk;

    // Synchronous ROM with one cycle of read latency.
    always @(posedge board_clk) rom_data <= rom_mem[rom_addr];

    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               last_m;
    int               exp_stall;
    logic [AW-1:0]    exp_rom_addr;
    logic [CIDXW-1:0] exp_data [N];
    logic [N-1:0]     exp_gnt;
    ret_t             retq [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Compare the registered outputs against the model at the start of cycle cyc.
    task automatic check_regs();
        logic [N-1:0]       ev;
        logic [N*CIDXW-1:0] ed;
        ret_t               r;
        ev = '0;
        if (retq.size() > 0 && retq[0].due == cyc) begin
            r = retq.pop_front();
            ev[r.id] = 1'b1;
            exp_data[r.id] = r.data;
        end
        for (int i = 0; i < N; i++) ed[i*CIDXW +: CIDXW] = exp_data[i];
        check("rd_valid",  64'(bus.rd_valid), 64'(ev));
        check("rd_data",   64'(bus.rd_data),  64'(ed));
        check("rom_addr",  64'(rom_addr),     64'(exp_rom_addr));
        check("stall_cnt", 64'(stall_cnt),    64'(exp_stall));
    endtask

    // Run one cycle: check the registered outputs, drive the inputs, check
    // the grant, then update the model.
    task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a);
        int win;
        @(negedge board_clk);
        check_regs();
        bus.req  = r;
        bus.addr = a;
        #1;
        exp_gnt = '0;
        win     = -1;
        if (!Reset) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last_m + k) % N;
                if (win < 0 && r[c]) win = c;
            end
        end
        if (win >= 0) exp_gnt[win] = 1'b1;
        check("gnt", 64'(bus.gnt), 64'(exp_gnt));
        if (win >= 0) begin
            last_m       = win;
            exp_rom_addr = a[win*AW +: AW];
            retq.push_back('{cyc + LAT + 2, win, rom_mem[a[win*AW +: AW]]});
        end
`ifdef SPRITE_ROM_STATS_EN
        if (!Reset && (r & ~exp_gnt) != '0 && exp_stall < 65535) exp_stall++;
`endif
        cyc++;
    endtask

    task automatic model_reset();
        retq.delete();
        last_m       = N - 1;
        exp_rom_addr = '0;
        exp_stall    = 0;
        for (int i = 0; i < N; i++) exp_data[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge board_clk);
        Reset   = 1'b1;
        bus.req = '0;
        model_reset();
        step('0, '0);
        step('0, '0);
        Reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0);
    endtask

    logic [N*AW-1:0] a;
    logic [N-1:0]    pend;
    logic [AW-1:0]   paddr [N];

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = CIDXW'($urandom_range(0, 7));
        rom_mem[37] = 3'd5;
        bus.req  = '0;
        bus.addr = '0;
        model_reset();

        // Reset release followed by an idle interface.
        do_reset();
        idle(10);

        // Single request from client 2.
        a = '0;
        a[2*AW +: AW] = AW'(37);
        step(4'b0100, a);
        idle(5);

        // All four clients request continuously: grants rotate 0,1,2,3.
        do_reset();
        for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(100 + i);
        for (int c = 0; c < 16; c++) step(4'b1111, a);
        idle(5);

        // Client 1 alone issues three back-to-back reads.
        for (int j = 0; j < 3; j++) begin
            a = '0;
            a[1*AW +: AW] = AW'(5 + j);
            step(4'b0010, a);
        end
        idle(5);

        // Reset with reads in flight for clients 0 and 3.
        do_reset();
        for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(200 + i);
        step(4'b1001, a);
        step(4'b1000, a);
        do_reset();
        idle(6);
        step(4'b1111, a);
        idle(5);

        // Randomized clients that follow the handshake, with some withdrawals.
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[i]  = 1'b1;
                        paddr[i] = AW'($urandom_range(0, CATROMDEPTH - 1));
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) a[i*AW +: AW] = paddr[i];
            step(pend, a);
            pend = pend & ~exp_gnt;
        end
        idle(6);
        check("drain", 64'(retq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
